// File: rtl/snn_vote_pkg.sv
// Shared widths, defaults and FSM state type for the spike vote decoder
// and the FC/LIF layers that feed it.
package snn_vote_pkg;

    // Defaults shared with the FC/LIF layers
    localparam int unsigned DefOutputNodes = 20;
    localparam int unsigned DefNumClasses  = 10;
    localparam int unsigned DefGroup       = 2;
    localparam int unsigned DefStep        = 25;

    // Per-neuron and step counter width: holds 0..step
    function automatic int unsigned cnt_width(input int unsigned step);
        return $clog2(step + 1);
    endfunction

    // Class score width: holds 0..group*step
    function automatic int unsigned score_width(input int unsigned group,
                                                input int unsigned step);
        return $clog2(group * step + 1);
    endfunction

    // Class index width, never narrower than one bit
    function automatic int unsigned class_width(input int unsigned num_classes);
        return (num_classes <= 1) ? 1 : $clog2(num_classes);
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } vote_state_e;

endpackage

// File: rtl/class_argmax_seq.sv
// Sequential argmax over a score snapshot, one class per cycle.
// Ties resolve to the lowest class index; a new start restarts the scan.
module class_argmax_seq
    import snn_vote_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DefNumClasses,
    parameter int unsigned SW          = score_width(DefGroup, DefStep),
    parameter int unsigned CLW         = class_width(DefNumClasses)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUM_CLASSES-1:0][SW-1:0]   scores,
    output logic                             busy,
    output logic                             done,
    output logic [CLW-1:0]                   best_idx,
    output logic [SW-1:0]                    best_score
);

    vote_state_e    state_q;
    logic [CLW-1:0] idx_q;
    logic [CLW-1:0] lead_idx_q;
    logic [SW-1:0]  lead_score_q;
    logic           done_q;
    logic [CLW-1:0] res_idx_q;
    logic [SW-1:0]  res_score_q;

    // Scan sequencing: abort beats start, start beats the running scan
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            lead_idx_q   <= '0;
            lead_score_q <= '0;
            done_q       <= 1'b0;
            res_idx_q    <= '0;
            res_score_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
            end else if (start) begin
                state_q      <= StScan;
                idx_q        <= '0;
                lead_idx_q   <= '0;
                lead_score_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StIdle;
                    end
                    StScan: begin
                        // Strict compare keeps the earliest class on a tie
                        if (scores[idx_q] > lead_score_q) begin
                            lead_score_q <= scores[idx_q];
                            lead_idx_q   <= idx_q;
                        end
                        if (idx_q == CLW'(NUM_CLASSES - 1)) begin
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    StDone: begin
                        done_q      <= 1'b1;
                        res_idx_q   <= lead_idx_q;
                        res_score_q <= lead_score_q;
                        state_q     <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign best_idx   = res_idx_q;
    assign best_score = res_score_q;

endmodule

// File: rtl/spike_vote_decoder.sv
// Accumulates per-neuron spike counts over a STEP-timestep window, snapshots
// per-class totals at window end and hands them to a sequential argmax.
module spike_vote_decoder
    import snn_vote_pkg::*;
#(
    parameter int unsigned OUTPUT_NODES = DefOutputNodes,
    parameter int unsigned NUM_CLASSES  = DefNumClasses,
    parameter int unsigned GROUP        = DefGroup,
    parameter int unsigned STEP         = DefStep
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         spk1_en,
    input  logic [0:OUTPUT_NODES-1]                      spk_1,
    input  logic                                         frame_clr,
    output logic                                         result_valid,
    output logic [class_width(NUM_CLASSES)-1:0]          result_class,
    output logic [score_width(GROUP, STEP)-1:0]          result_score,
    output logic                                         busy,
    output logic                                         overrun
);

    localparam int unsigned CW  = cnt_width(STEP);
    localparam int unsigned SW  = score_width(GROUP, STEP);
    localparam int unsigned CLW = class_width(NUM_CLASSES);

    if (OUTPUT_NODES != NUM_CLASSES * GROUP) begin : g_param_check
        $error("spike_vote_decoder: OUTPUT_NODES must equal NUM_CLASSES*GROUP");
    end

    logic [CW-1:0]                 cnt_q [OUTPUT_NODES];
    logic [CW-1:0]                 step_q;
    logic [NUM_CLASSES-1:0][SW-1:0] score_d;
    logic [NUM_CLASSES-1:0][SW-1:0] score_q;
    logic                          overrun_q;
    logic                          win_end;
    logic                          scan_busy;

    // frame_clr drops a simultaneous spk1_en, so it can never end a window
    assign win_end = spk1_en && !frame_clr && (step_q == CW'(STEP - 1));

    // Class totals including the spikes of the final timestep
    always_comb begin
        score_d = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int g = 0; g < GROUP; g++) begin
                score_d[c] = score_d[c] + SW'(cnt_q[c*GROUP+g]) + SW'(spk_1[c*GROUP+g]);
            end
        end
    end

    // Per-neuron and step counters; cleared at window end for a gapless next window
    always_ff @(posedge clk) begin
        if (!reset || frame_clr) begin
            step_q <= '0;
            for (int n = 0; n < OUTPUT_NODES; n++) cnt_q[n] <= '0;
        end else if (spk1_en) begin
            if (step_q == CW'(STEP - 1)) begin
                step_q <= '0;
                for (int n = 0; n < OUTPUT_NODES; n++) cnt_q[n] <= '0;
            end else begin
                step_q <= step_q + 1'b1;
                for (int n = 0; n < OUTPUT_NODES; n++) cnt_q[n] <= cnt_q[n] + CW'(spk_1[n]);
            end
        end
    end

    // Score snapshot held stable for the argmax scan
    always_ff @(posedge clk) begin
        if (!reset) begin
            score_q <= '0;
        end else if (win_end) begin
            score_q <= score_d;
        end
    end

    // Sticky flag: a window ended before the previous decision was emitted
    always_ff @(posedge clk) begin
        if (!reset || frame_clr) begin
            overrun_q <= 1'b0;
        end else if (win_end && scan_busy) begin
            overrun_q <= 1'b1;
        end
    end

    class_argmax_seq #(
        .NUM_CLASSES (NUM_CLASSES),
        .SW          (SW),
        .CLW         (CLW)
    ) u_argmax (
        .clk        (clk),
        .reset      (reset),
        .start      (win_end),
        .abort      (frame_clr),
        .scores     (score_q),
        .busy       (scan_busy),
        .done       (result_valid),
        .best_idx   (result_class),
        .best_score (result_score)
    );

    assign busy    = scan_busy;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_spike_vote_decoder.sv
// Randomized and directed bench for spike_vote_decoder against a
// timestamp-based window/argmax model.
module tb_spike_vote_decoder;

    localparam int ON = 20;
    localparam int NC = 10;
    localparam int GR = 2;
    localparam int ST = 25;

    logic          clk;
    logic          reset;
    logic          spk1_en;
    logic [0:ON-1] spk_1;
    logic          frame_clr;
    logic          result_valid;
    logic [3:0]    result_class;
    logic [5:0]    result_score;
    logic          busy;
    logic          overrun;

    // Short-window instance so two window ends can land 5 cycles apart
    logic          s_en;
    logic [0:ON-1] s_spk;
    logic          s_clr;
    logic          s_valid;
    logic [3:0]    s_class;
    logic [3:0]    s_score;
    logic          s_busy;
    logic          s_overrun;

    spike_vote_decoder #(
        .OUTPUT_NODES (ON),
        .NUM_CLASSES  (NC),
        .GROUP        (GR),
        .STEP         (ST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spk1_en      (spk1_en),
        .spk_1        (spk_1),
        .frame_clr    (frame_clr),
        .result_valid (result_valid),
        .result_class (result_class),
        .result_score (result_score),
        .busy         (busy),
        .overrun      (overrun)
    );

    spike_vote_decoder #(
        .OUTPUT_NODES (ON),
        .NUM_CLASSES  (NC),
        .GROUP        (GR),
        .STEP         (4)
    ) dut_short (
        .clk          (clk),
        .reset        (reset),
        .spk1_en      (s_en),
        .spk_1        (s_spk),
        .frame_clr    (s_clr),
        .result_valid (s_valid),
        .result_class (s_class),
        .result_score (s_score),
        .busy         (s_busy),
        .overrun      (s_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int counts [ON];
    int m_step, m_ov, m_cls, m_score;
    int pend, due, p_cls, p_score;
    int edge_n, win_edge, valid_edge;
    int n_valid, s_nvalid;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d (edge %0d)", tag, got, want, edge_n);
    endtask

    function automatic logic [0:ON-1] onehot(input int n);
        logic [0:ON-1] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:ON-1] rand_vec(input int pct);
        logic [0:ON-1] v;
        for (int n = 0; n < ON; n++) v[n] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    // One clock: drive inputs, advance the model, then compare all outputs
    task automatic tick(input logic en, input logic [0:ON-1] vec, input logic clr);
        int exp_valid;
        int sums [NC];
        int best;
        spk1_en   = en;
        spk_1     = vec;
        frame_clr = clr;
        @(posedge clk);
        edge_n++;
        exp_valid = 0;
        if (!reset) begin
            for (int n = 0; n < ON; n++) counts[n] = 0;
            m_step = 0; m_ov = 0; m_cls = 0; m_score = 0; pend = 0;
        end else if (clr) begin
            for (int n = 0; n < ON; n++) counts[n] = 0;
            m_step = 0; m_ov = 0; pend = 0;
        end else begin
            if (en && m_step == ST - 1) begin
                for (int c = 0; c < NC; c++) begin
                    sums[c] = 0;
                    for (int g = 0; g < GR; g++) sums[c] += counts[c*GR+g] + int'(vec[c*GR+g]);
                end
                best = 0;
                for (int c = 1; c < NC; c++) if (sums[c] > sums[best]) best = c;
                for (int n = 0; n < ON; n++) counts[n] = 0;
                m_step = 0;
                if (pend != 0) m_ov = 1;
                pend = 1; due = edge_n + NC + 1; p_cls = best; p_score = sums[best];
                win_edge = edge_n;
            end else begin
                if (en) begin
                    for (int n = 0; n < ON; n++) counts[n] += int'(vec[n]);
                    m_step++;
                end
                if (pend != 0 && edge_n == due) begin
                    exp_valid = 1; m_cls = p_cls; m_score = p_score; pend = 0;
                end
            end
        end
        #1;
        if (result_valid) begin
            n_valid++;
            valid_edge = edge_n;
        end
        if (s_valid) s_nvalid++;
        check("valid", int'(result_valid), exp_valid);
        check("busy", int'(busy), pend);
        check("overrun", int'(overrun), m_ov);
        check("class", int'(result_class), m_cls);
        check("score", int'(result_score), m_score);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, rand_vec(50), 1'b0);
    endtask

    task automatic window(input logic [0:ON-1] vec, input int nsteps, input int gap);
        for (int i = 0; i < nsteps; i++) begin
            tick(1'b1, vec, 1'b0);
            idle(gap);
        end
    endtask

    task automatic stick(input logic en, input logic [0:ON-1] vec, input logic clr);
        s_en  = en;
        s_spk = vec;
        s_clr = clr;
        tick(1'b0, '0, 1'b0);
    endtask

    int base;

    initial begin
        edge_n = 0; n_valid = 0; s_nvalid = 0; win_edge = 0; valid_edge = 0;
        s_en = 1'b0; s_spk = '0; s_clr = 1'b0;
        reset = 1'b0;
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        reset = 1'b1;
        tick(1'b0, '0, 1'b0);

        // Neuron 6 only -> class 3, score 25, 11 edges after last spk1_en
        window(onehot(6), ST, 1);
        idle(14);
        check("tp1_class", int'(result_class), 3);
        check("tp1_score", int'(result_score), 25);
        check("tp1_latency", valid_edge - win_edge, 11);

        // Tie between class 0 and class 9 -> lowest index
        window(onehot(0) | onehot(19), ST, 0);
        idle(14);
        check("tp2_class", int'(result_class), 0);
        check("tp2_score", int'(result_score), 25);

        // All neurons, then neuron 18 ten times in a fresh window
        window('1, ST, 0);
        idle(14);
        check("tp3a_class", int'(result_class), 0);
        check("tp3a_score", int'(result_score), 50);
        for (int i = 0; i < ST; i++) tick(1'b1, (i < 10) ? onehot(18) : '0, 1'b0);
        idle(14);
        check("tp3b_class", int'(result_class), 9);
        check("tp3b_score", int'(result_score), 10);

        // frame_clr mid-window, with a dropped simultaneous spk1_en
        base = n_valid;
        window(onehot(4), 12, 1);
        tick(1'b1, onehot(4), 1'b1);
        window(onehot(2), ST, 1);
        idle(14);
        check("tp4_nvalid", n_valid - base, 1);
        check("tp4_class", int'(result_class), 1);
        check("tp4_score", int'(result_score), 25);

        // Two window ends 5 cycles apart on the STEP=4 instance
        s_nvalid = 0;
        stick(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) stick(1'b1, onehot(0), 1'b0);
        stick(1'b0, '0, 1'b0);
        check("ovr_before", int'(s_overrun), 0);
        for (int i = 0; i < 4; i++) stick(1'b1, onehot(10), 1'b0);
        for (int i = 0; i < 15; i++) stick(1'b0, '0, 1'b0);
        check("ovr_flag", int'(s_overrun), 1);
        check("ovr_nvalid", s_nvalid, 1);
        check("ovr_class", int'(s_class), 5);
        check("ovr_score", int'(s_score), 4);
        stick(1'b0, '0, 1'b1);
        check("ovr_cleared", int'(s_overrun), 0);
        stick(1'b0, '0, 1'b0);

        // Reset during SCAN: no decision, outputs back to zero
        base = n_valid;
        window(onehot(14), ST, 0);
        idle(4);
        reset = 1'b0;
        tick(1'b0, '0, 1'b0);
        check("rst_busy", int'(busy), 0);
        check("rst_class", int'(result_class), 0);
        check("rst_score", int'(result_score), 0);
        reset = 1'b1;
        idle(15);
        check("rst_nvalid", n_valid - base, 0);

        // Random windows with sparse spikes, gaps and occasional frame_clr
        for (int w = 0; w < 14; w++) begin
            int pct;
            pct = $urandom_range(5, 60);
            for (int i = 0; i < ST; i++) begin
                tick(1'b1, rand_vec(pct), ($urandom_range(0, 59) == 0));
                idle($urandom_range(0, 2));
            end
            idle($urandom_range(0, 14));
        end
        idle(15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
